rand_rotation_pool: RTL

- Parametrised randomness pool: holds one WIDTH-bit fresh-mask word and serves TAPS+1 byte-rotated copies per cycle to masked S-box/gadget instances.
- Each copy is a distinct rotation of the pool. The pool advances by a full tap span per consume, so one fresh word is reused across up to MAX_USES consumes before a refill is required.
- Sits between the PRNG/fresh-randomness interface and the masked round datapath.

---
 rtl/rand_rotation_pool.sv | 80 ++++++++
 1 files changed

// File: rtl/rand_rotation_pool.sv
// rand_rotation_pool: one fresh-mask word served as TAPS+1 byte-rotated copies,
// advancing by a full tap span per consume and reused up to MAX_USES times.
module rand_rotation_pool #(
    parameter int WIDTH    = 216,
    parameter int STEP     = 8,
    parameter int TAPS     = 7,
    parameter int MAX_USES = 4,
    parameter int MIX_MODE = 0,
    parameter int CW       = $clog2(MAX_USES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          fresh_in,
    input  logic                      fresh_valid,
    output logic                      fresh_ready,
    input  logic                      adv,
    output logic                      r_valid,
    output logic [(TAPS+1)*WIDTH-1:0] r_out,
    output logic [CW-1:0]             uses_left,
    output logic                      underflow
);
    typedef enum logic {EMPTY, READY} state_t;

    localparam int ADV = ((TAPS + 1) * STEP) % WIDTH;
    localparam logic [CW-1:0] MAXC = CW'(MAX_USES);
    localparam logic [CW-1:0] LAST = CW'(MAX_USES - 1);

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_pool, w_pool_nx;
    logic [CW-1:0]    r_use_cnt, w_cnt_nx;
    logic             r_underflow;

    // Shift by WIDTH yields zero, so a rotation of 0 returns v unchanged.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int s);
        return (v >> s) | (v << (WIDTH - s));
    endfunction

    genvar k;
    generate
        for (k = 0; k <= TAPS; k++) begin : g_tap
            assign r_out[k*WIDTH +: WIDTH] = rotr(r_pool, (k * STEP) % WIDTH);
        end
    endgenerate

    assign fresh_ready = (r_state == EMPTY);
    assign r_valid     = (r_state == READY);
    assign uses_left   = (r_state == READY) ? MAXC - r_use_cnt : '0;
    assign underflow   = r_underflow;

    always_comb begin
        w_state_nx = r_state;
        w_pool_nx  = r_pool;
        w_cnt_nx   = r_use_cnt;
        if (r_state == EMPTY) begin
            if (fresh_valid) begin
                w_pool_nx  = (MIX_MODE != 0) ? r_pool ^ fresh_in : fresh_in;
                w_cnt_nx   = '0;
                w_state_nx = READY;
            end
        end else if (adv) begin
            w_pool_nx  = rotr(r_pool, ADV);
            w_cnt_nx   = (r_use_cnt == LAST) ? '0 : r_use_cnt + 1'b1;
            w_state_nx = (r_use_cnt == LAST) ? EMPTY : READY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_pool      <= '0;
            r_use_cnt   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pool      <= w_pool_nx;
            r_use_cnt   <= w_cnt_nx;
            r_underflow <= r_underflow | ((r_state == EMPTY) & adv);
        end
    end
endmodule
